pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/hazard_pkg.sv | 9 +
 rtl/hazard_sat_counter.sv | 13 +
 rtl/pipeline_hazard_ctrl.sv | 65 ++++++
 tb/tb_pipeline_hazard_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state encoding and default register-index width for the hazard controller
package hazard_pkg;
  localparam int REG_ADDR_W_DEF = 5;
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FLUSH    = 2'b10
  } state_t;
endpackage

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter: saturating event counter (clk, rst async high, inc -> count, sticks at all-ones)
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use/branch/mem-busy hazard FSM driving stage enables and flushes; stats counters under HAZARD_STATS_EN
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ID_EXE_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EXE_rd,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  ID_EXE_Write,
  output logic                  EXE_MEM_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EXE_Flush,
  output logic                  MEM_WB_Flush,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);
  state_t state, eff, nxt;
  logic [1:0] cnt, cnt_nxt;
  logic load_use, br, lu;
  // MEM_WAIT resolves to whichever state it froze; the frozen counter tells which
  always_comb begin
    load_use      = ID_EXE_MemRead && ID_EXE_rd != '0 && (ID_EXE_rd == IF_ID_rs1 || ID_EXE_rd == IF_ID_rs2);
    eff           = (state == MEM_WAIT) ? ((cnt != 2'd0) ? FLUSH : RUN) : state;
    br            = branch_taken && !mem_busy;
    lu            = load_use && !mem_busy && !branch_taken && eff == RUN;
    PC_Write      = !mem_busy && !lu;
    IF_ID_Write   = !mem_busy && !lu;
    ID_EXE_Write  = !mem_busy;
    EXE_MEM_Write = !mem_busy;
    IF_ID_Flush   = !mem_busy && (branch_taken || eff == FLUSH);
    ID_EXE_Flush  = br || lu;
    MEM_WB_Flush  = mem_busy;
    nxt           = mem_busy ? MEM_WAIT
                  : br ? ((FLUSH_CYCLES > 1) ? FLUSH : RUN)
                  : (eff == FLUSH && cnt > 2'd1) ? FLUSH : RUN;
    cnt_nxt       = mem_busy ? cnt
                  : br ? 2'(FLUSH_CYCLES - 1)
                  : (eff == FLUSH) ? cnt - 2'd1 : 2'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
`ifdef HAZARD_STATS_EN
  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(!PC_Write), .count(stall_cycles));
  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush (.clk(clk), .rst(rst), .inc(br), .count(flush_events));
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed + random checks of three controller instances (FLUSH_CYCLES 1,3,4) against a behavioural model
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1, mr = 1'b0, bt = 1'b0, mb = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0][6:0] o;
  logic [2:0][15:0] sc, fe;
  int fcs[3] = '{1, 3, 4};
  int rem[3], stl[3], fev[3];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipeline_hazard_ctrl #(.FLUSH_CYCLES(g == 0 ? 1 : g + 2)) u_dut (
      .clk(clk), .rst(rst), .ID_EXE_MemRead(mr), .ID_EXE_rd(rd),
      .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .branch_taken(bt), .mem_busy(mb),
      .PC_Write(o[g][6]), .IF_ID_Write(o[g][5]), .ID_EXE_Write(o[g][4]),
      .EXE_MEM_Write(o[g][3]), .IF_ID_Flush(o[g][2]), .ID_EXE_Flush(o[g][1]),
      .MEM_WB_Flush(o[g][0]), .stall_cycles(sc[g]), .flush_events(fe[g])
    );
  end
  task automatic chk(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[fc=%0d] obs=%0h exp=%0h", tag, fcs[i], obs, exp);
    end
  endtask
  // expected {PC,IFW,IDW,EXW,IFF,IDF,MWF} from the priority rules and remaining flush cycles
  function automatic logic [6:0] expv(input int i);
    logic lu;
    lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
    if (mb) return 7'b0000001;
    if (bt) return 7'b1111110;
    if (rem[i] > 0) return 7'b1111100;
    if (lu) return 7'b0011010;
    return 7'b1111000;
  endfunction
  function automatic logic [15:0] exp_stat(input int v);
`ifdef HAZARD_STATS_EN
    return 16'(v);
`else
    return 16'(v * 0);
`endif
  endfunction
  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_out"}, i, 16'(o[i]), 16'(expv(i)));
      chk({tag, "_stall"}, i, sc[i], exp_stat(stl[i]));
      chk({tag, "_flush"}, i, fe[i], exp_stat(fev[i]));
    end
  endtask
  task automatic step(input string tag, input logic m, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic b, input logic busy);
    logic [6:0] e;
    mr = m; rd = d; rs1 = s1; rs2 = s2; bt = b; mb = busy;
    #1;
    check_all(tag);
    for (int i = 0; i < 3; i++) begin
      e = expv(i);
      if (!e[6] && stl[i] < 65535) stl[i]++;
      if (bt && !mb && fev[i] < 65535) fev[i]++;
      if (!mb) rem[i] = bt ? fcs[i] - 1 : (rem[i] > 0 ? rem[i] - 1 : 0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin rem[i] = 0; stl[i] = 0; fev[i] = 0; end
    #2;
    check_all("in_reset");
    @(negedge clk);
    rst = 1'b0;
    idle("after_reset", 1);
    step("load_use", 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0);
    idle("post_lu", 1);
    step("rd_zero", 1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    step("branch", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle("flushing", 4);
    step("br_hold", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle("flush1", 1);
    for (int k = 0; k < 4; k++) step("busy", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle("post_busy", 3);
    step("busy_all", 1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b1);
    step("busy_all2", 1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b1);
    step("released", 1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0);
    step("lu_in_flush", 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0);
    idle("drain", 4);
    step("br_rst", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle("pre_rst", 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin rem[i] = 0; stl[i] = 0; fev[i] = 0; end
    #1;
    check_all("mid_rst");
    #1 rst = 1'b0;
    idle("post_rst", 2);
    for (int k = 0; k < 400; k++)
      step("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
